// File: rtl/axis_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after ptr,
// wrapping from N-1 back to 0.
module axis_rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W:0] pos_s;

  // Scan offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    valid = 1'b0;
    idx   = {W{1'b0}};
    pos_s = {(W+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      pos_s = {1'b0, ptr} + (W+1)'(i);
      if (pos_s >= (W+1)'(N)) begin
        pos_s = pos_s - (W+1)'(N);
      end else begin
        pos_s = pos_s;
      end
      if (req[pos_s[W-1:0]]) begin
        valid = 1'b1;
        idx   = pos_s[W-1:0];
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter: N byte-wide inputs, grant held until tlast.
// Optional idle-beat watchdog enabled by defining AXIS_ARB_TIMEOUT_EN.
module axis_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [8*N-1:0] i_tdata,
  input  logic [N-1:0]   i_tlast,
  input  logic [N-1:0]   i_tvalid,
  output logic [N-1:0]   o_tready,
  output logic [7:0]     o_tdata,
  output logic           o_tlast,
  output logic           o_tvalid,
  input  logic           i_tready
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]   state_r;
  logic [W-1:0] grant_r;
  logic [W-1:0] ptr_r;

  logic         pick_valid_s;
  logic [W-1:0] pick_idx_s;
  logic         accept_s;
  logic         release_s;
  logic         timeout_s;
  logic [W-1:0] next_ptr_s;

  axis_rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req   (i_tvalid),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign accept_s   = (state_r == LOCKED) & i_tvalid[grant_r] & i_tready;
  assign release_s  = (accept_s & i_tlast[grant_r]) | timeout_s;
  assign next_ptr_s = (grant_r == W'(N - 1)) ? {W{1'b0}} : grant_r + W'(1);

`ifdef AXIS_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt_r;

  // Stalls by the emitter (valid high, ready low) never count as idle.
  assign timeout_s = (state_r == LOCKED) & ~i_tvalid[grant_r] &
                     ((idle_cnt_r + 16'd1) == 16'(TIMEOUT));

  // Idle-beat counter: cleared while arbitrating and on every accepted beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt_r <= 16'd0;
    end else if (state_r == IDLE) begin
      idle_cnt_r <= 16'd0;
    end else if (accept_s) begin
      idle_cnt_r <= 16'd0;
    end else if (~i_tvalid[grant_r]) begin
      idle_cnt_r <= idle_cnt_r + 16'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Arbitration FSM: pick in IDLE, hold the grant until release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      grant_r <= {W{1'b0}};
      ptr_r   <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_idx_s;
            state_r <= LOCKED;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (release_s) begin
            state_r <= IDLE;
            ptr_r   <= next_ptr_s;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency pass-through of the granted input; everything low otherwise.
  always_comb begin
    o_tdata  = 8'h00;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    o_tready = {N{1'b0}};
    if (state_r == LOCKED) begin
      o_tdata           = i_tdata[{grant_r, 3'b000} +: 8];
      o_tlast           = i_tlast[grant_r];
      o_tvalid          = i_tvalid[grant_r];
      o_tready[grant_r] = i_tready;
    end else begin
      o_tdata  = 8'h00;
      o_tlast  = 1'b0;
      o_tvalid = 1'b0;
      o_tready = {N{1'b0}};
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter (N=4, TIMEOUT=8); per-input AXIS sources
// feed the DUT while a monitor checks every accepted beat against expectations.
module tb_axis_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [2:0] s;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [8*N-1:0] i_tdata;
  logic [N-1:0]   i_tlast;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   o_tready;
  logic [7:0]     o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           i_tready;

  beat_t src_q [N][$];
  exp_t  exp_q [$];

  int checks = 0;
  int errors = 0;
  bit gap_chk = 1'b0;

  axis_rr_arbiter #(.N(N), .TIMEOUT(8)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic src(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q[k].push_back(b);
  endtask

  task automatic expect_beat(input int k, input logic [7:0] d, input logic l);
    exp_t e;
    e.s = 3'(k);
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  function automatic int src_pending();
    int n = 0;
    for (int k = 0; k < N; k++) n += src_q[k].size();
    return n;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_beat(input string nm, input int k, input logic [7:0] d);
    bit hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (o_tvalid && i_tready && o_tready[k] && o_tdata == d) hit = 1'b1;
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  // AXIS sources: acceptance sampled on the falling edge, queues advance after the rising edge.
  initial begin
    logic [N-1:0] acc;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    forever begin
      @(negedge clk);
      acc = i_rst ? '0 : (i_tvalid & o_tready & {N{i_tready}});
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          i_tvalid[k]           = 1'b1;
          i_tlast[k]            = src_q[k][0].l;
          i_tdata[8*k +: 8]     = src_q[k][0].d;
        end else begin
          i_tvalid[k]           = 1'b0;
          i_tlast[k]            = 1'b0;
          i_tdata[8*k +: 8]     = 8'h00;
        end
      end
    end
  end

  // Monitor: every transferred beat is popped from the scoreboard and compared.
  initial begin
    int   cyc = 0;
    int   last_cyc = 0;
    bit   prev_last = 1'b0;
    logic [2:0] idx;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_chk) prev_last = 1'b0;
      if (!i_rst && o_tvalid && i_tready) begin
        idx = 3'd7;
        for (int k = N - 1; k >= 0; k--) if (o_tready[k]) idx = 3'(k);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, o_tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_src", 32'(idx), 32'(e.s));
          chk("beat_data", 32'(o_tdata), 32'(e.d));
          chk("beat_last", 32'(o_tlast), 32'(e.l));
        end
        if (gap_chk && prev_last) chk("packet_gap", cyc - last_cyc, 2);
        prev_last = o_tlast;
        last_cyc  = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    i_rst    = 1'b1;
    i_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tready", 32'(o_tready), 32'd0);
    chk("rst_tdata", 32'(o_tdata), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    step();
    i_rst    = 1'b0;
    i_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_tvalid", 32'(o_tvalid), 32'd0);
      chk("idle_tready", 32'(o_tready), 32'd0);
    end

    // Single packet from input 2, one arbitration cycle before the first beat.
    step();
    src(2, 8'h48, 1'b0); src(2, 8'h69, 1'b0); src(2, 8'h0A, 1'b1);
    expect_beat(2, 8'h48, 1'b0); expect_beat(2, 8'h69, 1'b0); expect_beat(2, 8'h0A, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (i_tvalid[2]) seen = 1'b1;
    end
    chk("single_req_seen", 32'(seen), 32'd1);
    chk("single_arb_cycle", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    chk("single_first_valid", 32'(o_tvalid), 32'd1);
    chk("single_first_ready", 32'(o_tready), 32'b0100);
    drain("single_drain");
    @(negedge clk);
    chk("single_back_idle", 32'(o_tvalid), 32'd0);

    // Pointer now 3: with 0 and 3 both requesting, 3 goes first.
    step();
    src(0, 8'hA0, 1'b1); src(3, 8'hD0, 1'b1);
    expect_beat(3, 8'hD0, 1'b1); expect_beat(0, 8'hA0, 1'b1);
    drain("ptr3_drain");

    step();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;

    // Fairness: all four continuously requesting 2-beat packets.
    gap_chk = 1'b1;
    src(0, 8'h01, 1'b0); src(0, 8'h02, 1'b1); src(0, 8'h05, 1'b0); src(0, 8'h06, 1'b1);
    src(1, 8'h11, 1'b0); src(1, 8'h12, 1'b1);
    src(2, 8'h21, 1'b0); src(2, 8'h22, 1'b1);
    src(3, 8'h31, 1'b0); src(3, 8'h32, 1'b1);
    expect_beat(0, 8'h01, 1'b0); expect_beat(0, 8'h02, 1'b1);
    expect_beat(1, 8'h11, 1'b0); expect_beat(1, 8'h12, 1'b1);
    expect_beat(2, 8'h21, 1'b0); expect_beat(2, 8'h22, 1'b1);
    expect_beat(3, 8'h31, 1'b0); expect_beat(3, 8'h32, 1'b1);
    expect_beat(0, 8'h05, 1'b0); expect_beat(0, 8'h06, 1'b1);
    drain("rr_drain");
    @(negedge clk);
    gap_chk = 1'b0;

    // Backpressure on input 1 while input 3 waits.
    step();
    src(1, 8'hB1, 1'b0); src(1, 8'hB2, 1'b0); src(1, 8'hB3, 1'b0); src(1, 8'hB4, 1'b1);
    expect_beat(1, 8'hB1, 1'b0); expect_beat(1, 8'hB2, 1'b0);
    expect_beat(1, 8'hB3, 1'b0); expect_beat(1, 8'hB4, 1'b1);
    expect_beat(3, 8'h33, 1'b1);
    wait_beat("bp_first_beat", 1, 8'hB1);
    step();
    i_tready = 1'b0;
    src(3, 8'h33, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data_stable", 32'(o_tdata), 32'hB2);
      chk("bp_tvalid", 32'(o_tvalid), 32'd1);
      chk("bp_tready", 32'(o_tready), 32'd0);
    end
    step();
    i_tready = 1'b1;
    drain("bp_drain");

    // Reset after beat 2 of 4 from input 0; the cut packet is dropped.
    step();
    src(0, 8'hC1, 1'b0); src(0, 8'hC2, 1'b0); src(0, 8'hC3, 1'b0); src(0, 8'hC4, 1'b1);
    expect_beat(0, 8'hC1, 1'b0); expect_beat(0, 8'hC2, 1'b0);
    wait_beat("rst_mid_beat2", 0, 8'hC2);
    step();
    i_rst    = 1'b1;
    i_tready = 1'b0;
    src_q[0].delete();
    src(0, 8'hE0, 1'b0); src(0, 8'hE1, 1'b1);
    src(2, 8'hE2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_mid_tready", 32'(o_tready), 32'd0);
    chk("rst_mid_tdata", 32'(o_tdata), 32'd0);
    chk("rst_mid_tlast", 32'(o_tlast), 32'd0);
    step();
    i_rst    = 1'b0;
    i_tready = 1'b1;
    expect_beat(0, 8'hE0, 1'b0); expect_beat(0, 8'hE1, 1'b1); expect_beat(2, 8'hE2, 1'b1);
    drain("rst_mid_drain");

    // Input 1 sends one beat then goes silent; pointer is 3 so 1 wins over 2.
    step();
    src(1, 8'h10, 1'b0);
    src(2, 8'h20, 1'b1);
    expect_beat(1, 8'h10, 1'b0);
`ifdef AXIS_ARB_TIMEOUT_EN
    expect_beat(2, 8'h20, 1'b1);
    wait_beat("to_first_beat", 1, 8'h10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_still_locked", 32'(o_tready), 32'b0010);
      chk("to_idle_tvalid", 32'(o_tvalid), 32'd0);
    end
    @(negedge clk);
    chk("to_released", 32'(o_tready), 32'd0);
    @(negedge clk);
    chk("to_next_grant", 32'(o_tready), 32'b0100);
    chk("to_next_valid", 32'(o_tvalid), 32'd1);
    drain("to_drain");
`else
    wait_beat("lock_first_beat", 1, 8'h10);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("lock_held", 32'(o_tready), 32'b0010);
    end
    step();
    src(1, 8'h11, 1'b1);
    expect_beat(1, 8'h11, 1'b1);
    expect_beat(2, 8'h20, 1'b1);
    drain("lock_drain");
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
